bus_transfer_ctrl: RTL and testbench
====================================

Name: bus_transfer_ctrl

Overview:
- Sequencer and bus resolver for the shared data bus feeding the bank of bus registers.
- Upstream of each register: drives its active-low assert and load strobes, and the common bus_in value.
- Downstream of each register: consumes every register's bus_out/bus_en and resolves them into the single bus value.
- Executes one register-to-register (or immediate-to-register) transfer per request.

Parameters:
- WIDTH, 8, bus width in bits.
- NUM_REGS, 8, number of attached registers.
- IDX_W, $clog2(NUM_REGS), register index width.
- PULL_VALUE, {WIDTH{1'b1}}, bus value when nothing drives (pulled up).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  transfer request.
- req_ready  out  1  high only in IDLE.
- req_src  in  IDX_W  source register index (ignored when req_imm_en=1).
- req_dst  in  IDX_W  destination register index.
- req_imm_en  in  1  drive req_imm onto the bus instead of a register.
- req_imm  in  WIDTH  immediate value.
- src_bus_out  in  NUM_REGS*WIDTH  registers' bus_out, reg i at [i*WIDTH +: WIDTH].
- src_bus_en  in  NUM_REGS  registers' bus_en, active-high.
- assert_n  out  NUM_REGS  per-register active-low assert strobe.
- load_n  out  NUM_REGS  per-register active-low load strobe.
- bus_value  out  WIDTH  resolved bus; wired to every register's bus_in.
- done  out  1  one-cycle completion pulse.
- done_data  out  WIDTH  bus value captured by the destination.
- done_err  out  1  valid with done: an index was >= NUM_REGS.
- contention  out  1  sticky: more than one bus driver seen at a clock edge.
- contention_clr  in  1  synchronous clear of contention.

Behaviour:
- Reset (async, while rst_n=0):
  - state=IDLE; assert_n and load_n all ones; done=0; done_err=0; done_data=0; contention=0; req_ready=1 after release.
  - Reset mid-transfer aborts the transfer; the strobes deassert immediately without waiting for clk.
- States: IDLE -> DRIVE -> LOAD -> IDLE. assert_n, load_n and done are flop outputs with no decode glitches.
- E0, IDLE with req_valid&&req_ready:
  - latch src, dst, imm_en, imm.
  - assert_n[src]<=0, unless imm_en or src out of range.
  - state<=DRIVE.
- E1, DRIVE: load_n[dst]<=0 if dst is in range; assert_n held; state<=LOAD. This cycle is a full settle cycle before the load.
- E2, LOAD:
  - the destination register captures bus_value on this edge.
  - assert_n and load_n <= all ones.
  - done<=1; done_data<=bus_value; done_err<=(any latched index out of range); state<=IDLE.
- done is high for exactly the cycle after E2.
- Throughput:
  - req_ready=1 in IDLE only, so the earliest next acceptance is the edge after E2, i.e. one transfer per 3 cycles.
  - req_valid outside IDLE is ignored; the request must be held until accepted.
- Bus resolution is combinational. Drivers = src_bus_en bits plus the latched imm_en while in DRIVE or LOAD.
  - 0 drivers -> bus_value=PULL_VALUE.
  - 1 driver -> that driver's value.
  - more than 1 -> bitwise AND of all driving values (wired-AND model).
- Contention flag:
  - set at any clk edge where the driver count is >1, regardless of state.
  - contention_clr clears it; a simultaneous set wins.
- Boundary cases:
  - src==dst is legal; the register reloads its own value.
  - imm_en=1 asserts no assert_n bit.
  - A dst out of range gives no load strobe, but done still pulses with done_err=1.
  - load_n never has more than one bit low; assert_n never has more than one bit low.

Decomposition:
- Package bus_ctrl_pkg: state enum typedef (IDLE, DRIVE, LOAD), 2-bit encoding.
- Sub-module bus_resolver (parameters WIDTH, NUM_REGS, PULL_VALUE):
  - inputs: src_bus_out, src_bus_en, imm, imm_drive.
  - outputs: bus_value, multi_drive.
  - purely combinational.

Test Plan:
- Reset: rst_n=0 asserted mid-DRIVE -> assert_n=8'hFF and load_n=8'hFF within the same cycle, with no clk edge needed; req_ready=1 after release.
- Reg transfer: reg3 holds 8'h5A, req src=3 dst=6.
  - E0+: assert_n=8'hF7.
  - E1+: load_n=8'hBF.
  - E2: reg6 captures 8'h5A; done=1, done_data=8'h5A.
- Immediate: req_imm_en=1, imm=8'h3C, dst=0 -> assert_n stays 8'hFF; reg0=8'h3C; done_data=8'h3C.
- Idle bus: no drivers -> bus_value=8'hFF; two drivers 8'hF0 and 8'h3C -> bus_value=8'h30 and contention=1, which stays set until contention_clr.
- Back-to-back: req_valid held high with two queued requests -> acceptances are 3 cycles apart, and req_ready=0 during DRIVE and LOAD.
- Range and self cases: NUM_REGS=6 with dst=7 -> no load_n bit low, done_err=1; src=dst=2 -> reg2 value unchanged, done_err=0.

Source files
------------

// File: rtl/bus_ctrl_pkg.sv
// Shared types and helpers for the bus transfer sequencer.
package bus_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2
  } bus_state_e;

  function automatic logic idx_in_range(input int unsigned idx, input int unsigned num_regs);
    return idx < num_regs;
  endfunction

endpackage

// File: rtl/bus_resolver.sv
// Combinational wired-AND resolver for the shared bus with a pull-up default.
module bus_resolver #(
  parameter int unsigned       WIDTH      = 8,
  parameter int unsigned       NUM_REGS   = 8,
  parameter logic [WIDTH-1:0]  PULL_VALUE = {WIDTH{1'b1}}
) (
  input  logic [NUM_REGS*WIDTH-1:0] src_bus_out,
  input  logic [NUM_REGS-1:0]       src_bus_en,
  input  logic [WIDTH-1:0]          imm,
  input  logic                      imm_drive,
  output logic [WIDTH-1:0]          bus_value,
  output logic                      multi_drive
);

  logic [WIDTH-1:0] wired;
  logic             seen;
  logic             multi;

  always_comb begin
    wired = '1;
    seen  = 1'b0;
    multi = 1'b0;
    if (imm_drive) begin
      wired = imm;
      seen  = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (src_bus_en[i]) begin
        wired = wired & src_bus_out[i*WIDTH +: WIDTH];
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    bus_value   = seen ? wired : PULL_VALUE;
    multi_drive = multi;
  end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Three-phase register-to-register transfer sequencer (drive, settle, load) with bus resolution.
module bus_transfer_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned       WIDTH      = 8,
  parameter int unsigned       NUM_REGS   = 8,
  parameter int unsigned       IDX_W      = $clog2(NUM_REGS),
  parameter logic [WIDTH-1:0]  PULL_VALUE = {WIDTH{1'b1}}
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [IDX_W-1:0]          req_src,
  input  logic [IDX_W-1:0]          req_dst,
  input  logic                      req_imm_en,
  input  logic [WIDTH-1:0]          req_imm,
  input  logic [NUM_REGS*WIDTH-1:0] src_bus_out,
  input  logic [NUM_REGS-1:0]       src_bus_en,
  output logic [NUM_REGS-1:0]       assert_n,
  output logic [NUM_REGS-1:0]       load_n,
  output logic [WIDTH-1:0]          bus_value,
  output logic                      done,
  output logic [WIDTH-1:0]          done_data,
  output logic                      done_err,
  output logic                      contention,
  input  logic                      contention_clr
);

  bus_state_e state_q, state_d;

  logic [IDX_W-1:0]    src_q, src_d;
  logic [IDX_W-1:0]    dst_q, dst_d;
  logic                imm_en_q, imm_en_d;
  logic [WIDTH-1:0]    imm_q, imm_d;
  logic [NUM_REGS-1:0] assert_n_q, assert_n_d;
  logic [NUM_REGS-1:0] load_n_q, load_n_d;
  logic                done_q, done_d;
  logic                done_err_q, done_err_d;
  logic [WIDTH-1:0]    done_data_q, done_data_d;
  logic                contention_q, contention_d;
  logic                imm_drive;
  logic                multi_drive;

  // Active-low strobe for one register; an out-of-range index yields no low bit.
  function automatic logic [NUM_REGS-1:0] strobe_for(input logic [IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] s;
    s = '1;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(idx) == i) s[i] = 1'b0;
    end
    return s;
  endfunction

  assign imm_drive = imm_en_q && (state_q == DRIVE || state_q == LOAD);

  bus_resolver #(
    .WIDTH      (WIDTH),
    .NUM_REGS   (NUM_REGS),
    .PULL_VALUE (PULL_VALUE)
  ) u_resolver (
    .src_bus_out (src_bus_out),
    .src_bus_en  (src_bus_en),
    .imm         (imm_q),
    .imm_drive   (imm_drive),
    .bus_value   (bus_value),
    .multi_drive (multi_drive)
  );

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    imm_en_d    = imm_en_q;
    imm_d       = imm_q;
    assert_n_d  = assert_n_q;
    load_n_d    = load_n_q;
    done_d      = 1'b0;
    done_err_d  = 1'b0;
    done_data_d = done_data_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          src_d    = req_src;
          dst_d    = req_dst;
          imm_en_d = req_imm_en;
          imm_d    = req_imm;
          if (!req_imm_en) assert_n_d = strobe_for(req_src);
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        load_n_d = strobe_for(dst_q);
        state_d  = LOAD;
      end
      LOAD: begin
        assert_n_d  = '1;
        load_n_d    = '1;
        done_d      = 1'b1;
        done_data_d = bus_value;
        done_err_d  = !idx_in_range(32'(dst_q), NUM_REGS) ||
                      (!imm_en_q && !idx_in_range(32'(src_q), NUM_REGS));
        state_d     = IDLE;
      end
      default: begin
        assert_n_d = '1;
        load_n_d   = '1;
        state_d    = IDLE;
      end
    endcase
  end

  // A new multi-driver observation wins over a simultaneous clear.
  assign contention_d = multi_drive | (contention_q & ~contention_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      imm_en_q     <= 1'b0;
      imm_q        <= '0;
      assert_n_q   <= '1;
      load_n_q     <= '1;
      done_q       <= 1'b0;
      done_err_q   <= 1'b0;
      done_data_q  <= '0;
      contention_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      imm_en_q     <= imm_en_d;
      imm_q        <= imm_d;
      assert_n_q   <= assert_n_d;
      load_n_q     <= load_n_d;
      done_q       <= done_d;
      done_err_q   <= done_err_d;
      done_data_q  <= done_data_d;
      contention_q <= contention_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign assert_n   = assert_n_q;
  assign load_n     = load_n_q;
  assign done       = done_q;
  assign done_err   = done_err_q;
  assign done_data  = done_data_q;
  assign contention = contention_q;

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Bench for bus_transfer_ctrl: six attached registers, directed cases plus random transfers.
module tb_bus_transfer_ctrl;

  localparam int unsigned NR = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_src;
  logic [2:0]    req_dst;
  logic          req_imm_en;
  logic [7:0]    req_imm;
  logic [NR*8-1:0] src_bus_out;
  logic [NR-1:0] src_bus_en;
  logic [NR-1:0] assert_n;
  logic [NR-1:0] load_n;
  logic [7:0]    bus_value;
  logic          done;
  logic [7:0]    done_data;
  logic          done_err;
  logic          contention;
  logic          contention_clr;

  // Attached register bank plus extra bus enables for forcing contention.
  logic [7:0]    regs [NR];
  logic [NR-1:0] extra_en;
  logic          pl_en;
  logic [2:0]    pl_idx;
  logic [7:0]    pl_val;

  // Reference contents of the register bank.
  logic [7:0]    exp_regs [NR];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bus_transfer_ctrl #(
    .WIDTH      (8),
    .NUM_REGS   (NR),
    .IDX_W      (3),
    .PULL_VALUE (8'hFF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_src        (req_src),
    .req_dst        (req_dst),
    .req_imm_en     (req_imm_en),
    .req_imm        (req_imm),
    .src_bus_out    (src_bus_out),
    .src_bus_en     (src_bus_en),
    .assert_n       (assert_n),
    .load_n         (load_n),
    .bus_value      (bus_value),
    .done           (done),
    .done_data      (done_data),
    .done_err       (done_err),
    .contention     (contention),
    .contention_clr (contention_clr)
  );

  always_comb begin
    for (int i = 0; i < NR; i++) src_bus_out[i*8 +: 8] = regs[i];
  end
  assign src_bus_en = ~assert_n | extra_en;

  always @(posedge clk) begin
    if (pl_en) regs[pl_idx] <= pl_val;
    for (int i = 0; i < NR; i++) begin
      if (!load_n[i]) regs[i] <= bus_value;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [2:0] idx, input logic [7:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
    exp_regs[idx] = val;
  endtask

  task automatic transfer(input logic [2:0] s, input logic [2:0] d, input logic ie,
                          input logic [7:0] iv);
    logic [7:0]    val;
    logic [NR-1:0] ea;
    logic [NR-1:0] el;
    logic          err;
    if (ie) val = iv;
    else if (s < NR) val = exp_regs[s];
    else val = 8'hFF;
    ea = '1;
    if (!ie && s < NR) ea[s] = 1'b0;
    el = '1;
    if (d < NR) el[d] = 1'b0;
    err = (d >= NR) || (!ie && s >= NR);

    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_src = s; req_dst = d; req_imm_en = ie; req_imm = iv;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("assert_n_e0", 32'(assert_n), 32'(ea));
    check("load_n_e0", 32'(load_n), 32'h3F);
    check("ready_drive", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("assert_n_e1", 32'(assert_n), 32'(ea));
    check("load_n_e1", 32'(load_n), 32'(el));
    check("bus_drive", 32'(bus_value), 32'(val));
    check("ready_load", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("done", 32'(done), 32'd1);
    check("done_data", 32'(done_data), 32'(val));
    check("done_err", 32'(done_err), 32'(err));
    check("strobes_off", 32'({assert_n, load_n}), 32'hFFF);
    if (d < NR) begin
      exp_regs[d] = val;
      check("reg_loaded", 32'(regs[d]), 32'(val));
    end
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int          acc_cyc [2];
    int          n;
    logic [2:0]  rs, rd;
    logic        rie;

    rst_n = 1'b0; req_valid = 1'b0; req_src = '0; req_dst = '0; req_imm_en = 1'b0;
    req_imm = '0; contention_clr = 1'b0; extra_en = '0; pl_en = 1'b0; pl_idx = '0;
    pl_val = '0;
    for (int i = 0; i < NR; i++) begin
      regs[i] = '0;
      exp_regs[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_assert_n", 32'(assert_n), 32'h3F);
    check("rst_load_n", 32'(load_n), 32'h3F);
    check("rst_done", 32'({done, done_err}), 32'd0);
    check("rst_done_data", 32'(done_data), 32'd0);
    check("rst_contention", 32'(contention), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(req_ready), 32'd1);
    check("idle_bus_pull", 32'(bus_value), 32'hFF);

    for (int i = 0; i < NR; i++) preload(3'(i), 8'($urandom));
    preload(3'd3, 8'h5A);

    // Register transfer and immediate.
    transfer(3'd3, 3'd5, 1'b0, 8'h00);
    check("reg5_5a", 32'(regs[5]), 32'h5A);
    transfer(3'd0, 3'd0, 1'b1, 8'h3C);
    check("reg0_3c", 32'(regs[0]), 32'h3C);

    // Range and self cases.
    transfer(3'd1, 3'd7, 1'b0, 8'h00);
    transfer(3'd2, 3'd2, 1'b0, 8'h00);
    check("self_unchanged", 32'(regs[2]), 32'(exp_regs[2]));

    // Contention: wired-AND of two drivers, sticky until cleared, set beats clear.
    check("cont_before", 32'(contention), 32'd0);
    preload(3'd0, 8'hF0);
    preload(3'd1, 8'h3C);
    @(negedge clk);
    extra_en = 6'b000011;
    #1;
    check("wired_and", 32'(bus_value), 32'h30);
    @(posedge clk); #1;
    check("cont_set", 32'(contention), 32'd1);
    extra_en = '0;
    @(posedge clk); #1;
    check("cont_sticky", 32'(contention), 32'd1);
    extra_en = 6'b000011; contention_clr = 1'b1;
    @(posedge clk); #1;
    check("cont_set_wins", 32'(contention), 32'd1);
    extra_en = '0;
    @(posedge clk); #1;
    check("cont_cleared", 32'(contention), 32'd0);
    contention_clr = 1'b0;

    // Back-to-back: request held high, acceptances three cycles apart.
    n = 0;
    acc_cyc[0] = -1; acc_cyc[1] = -1;
    req_valid = 1'b1; req_src = 3'd4; req_dst = 3'd3; req_imm_en = 1'b0; req_imm = 8'h00;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check("b2b_ready", 32'(req_ready), 32'((c % 3 == 0) || c >= 6));
      if (req_ready && req_valid && n < 2) begin
        acc_cyc[n] = c;
        n++;
      end
      @(posedge clk); #1;
      if (n == 1) begin
        req_src = 3'd0; req_dst = 3'd1; req_imm_en = 1'b1; req_imm = 8'hA5;
      end
      if (n == 2) req_valid = 1'b0;
    end
    check("b2b_count", 32'(n), 32'd2);
    check("b2b_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    exp_regs[3] = exp_regs[4];
    exp_regs[1] = 8'hA5;
    check("b2b_reg3", 32'(regs[3]), 32'(exp_regs[3]));
    check("b2b_reg1", 32'(regs[1]), 32'hA5);

    // Random transfers against the reference model.
    for (int k = 0; k < 25; k++) begin
      rie = 1'($urandom_range(0, 1));
      rs  = 3'($urandom_range(0, 7));
      rd  = 3'($urandom_range(0, 7));
      if (rie) rs = 3'($urandom_range(0, NR - 1));
      transfer(rs, rd, rie, 8'($urandom));
    end
    for (int i = 0; i < NR; i++) check("final_bank", 32'(regs[i]), 32'(exp_regs[i]));

    // Reset mid-DRIVE and mid-LOAD: strobes drop without a clock edge, no load happens.
    for (int depth = 1; depth <= 2; depth++) begin
      @(negedge clk);
      req_valid = 1'b1; req_src = 3'd4; req_dst = 3'd2; req_imm_en = 1'b0;
      repeat (depth) @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("pre_rst_assert", 32'(assert_n), 32'h2F);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_assert_n", 32'(assert_n), 32'h3F);
      check("async_load_n", 32'(load_n), 32'h3F);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_abort", 32'(req_ready), 32'd1);
      check("no_load_on_abort", 32'(regs[2]), 32'(exp_regs[2]));
      check("done_after_abort", 32'(done), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
